ext_int_arbiter: RTL

- Platform-level external interrupt controller sitting between SoC peripheral IRQ lines and the core trap logic.
- Latches and prioritises up to NUM_SRC sources and drives the core's meip line plus the 31-bit custom_int_code used as the external-interrupt mcause code.
- Provides a claim/complete handshake and a small register file on the peripheral bus, so each source has at most one interrupt in service at a time.

---
 rtl/ext_int_arbiter_pkg.sv | 16 +
 rtl/ext_int_arbiter_if.sv | 23 ++
 rtl/ext_int_prio_tree.sv | 25 ++
 rtl/ext_int_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ext_int_arbiter_pkg.sv
// Shared types and register map for the external interrupt arbiter.
package ext_int_arbiter_pkg;

   localparam logic [2:0] AddrPending   = 3'd0;
   localparam logic [2:0] AddrEnable    = 3'd1;
   localparam logic [2:0] AddrEdgeSel   = 3'd2;
   localparam logic [2:0] AddrThreshold = 3'd3;
   localparam logic [2:0] AddrClaim     = 3'd4;
   localparam logic [2:0] AddrPrio      = 3'd5;

   localparam int unsigned CodeBaseDefault = 16;

   typedef logic [2:0] prio_t;
   typedef logic [3:0] src_id_t;

endpackage

// File: rtl/ext_int_arbiter_if.sv
// Peripheral register bus plus IRQ lines and core-facing interrupt outputs.
interface ext_int_arbiter_if #(
   parameter int unsigned NUM_SRC = 8
);
   logic [NUM_SRC-1:0] irq_src;
   logic               wr_en;
   logic               rd_en;
   logic [2:0]         addr;
   logic [31:0]        wdata;
   logic [31:0]        rdata;
   logic               meip;
   logic [30:0]        custom_int_code;

   modport master (
      output irq_src, wr_en, rd_en, addr, wdata,
      input  rdata, meip, custom_int_code
   );

   modport slave (
      input  irq_src, wr_en, rd_en, addr, wdata,
      output rdata, meip, custom_int_code
   );
endinterface

// File: rtl/ext_int_prio_tree.sv
// Combinational selector: highest priority among valid entries, ties to the lowest ID.
module ext_int_prio_tree
   import ext_int_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = 8
) (
   input  logic [NUM_SRC-1:0]  valid,
   input  prio_t [NUM_SRC-1:0] prio,
   output src_id_t             win_id
);

   always_comb begin
      prio_t best;
      best   = '0;
      win_id = '0;
      // Ascending scan with strict compare keeps the lowest ID on ties.
      for (int i = 0; i < NUM_SRC; i++) begin
         if (valid[i] && ((win_id == '0) || (prio[i] > best))) begin
            best   = prio[i];
            win_id = src_id_t'(i + 1);
         end
      end
   end

endmodule

// File: rtl/ext_int_arbiter.sv
// Platform external interrupt controller: synchronises and latches IRQ lines, arbitrates by
// priority and offers claim/complete plus config registers on a small word-addressed bus.
module ext_int_arbiter
   import ext_int_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CODE_BASE   = CodeBaseDefault
) (
   input logic              clk,
   input logic              rst_sync_n,
   ext_int_arbiter_if.slave bus
);

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] s, s_prev_q, edge_det;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] enable_q, edge_sel_q, in_service_q;
   prio_t              thresh_q;
   prio_t [NUM_SRC-1:0] prio_q;
   src_id_t            win_id_q, win_id_d;
   logic [31:0]        rdata_q, rdata_d;

   logic               claim_hit, do_claim, complete_hit;
   logic [NUM_SRC-1:0] claim_mask, complete_mask, eligible;

   always_ff @(posedge clk) begin
      if (!rst_sync_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         s_prev_q <= '0;
      end else begin
         sync_q[0] <= bus.irq_src;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         s_prev_q <= s;
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign edge_det = s & ~s_prev_q;

   assign claim_hit    = bus.rd_en && (bus.addr == AddrClaim);
   assign do_claim     = claim_hit && (win_id_q != '0);
   assign complete_hit = bus.wr_en && (bus.addr == AddrClaim);

   // Completes of IDs not in service clear nothing, so no explicit in_service gate is needed.
   always_comb begin
      claim_mask    = '0;
      complete_mask = '0;
      eligible      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         claim_mask[i]    = do_claim && (win_id_q == src_id_t'(i + 1));
         complete_mask[i] = complete_hit && (bus.wdata == 32'(i + 1));
         eligible[i]      = pending_q[i] && enable_q[i] && !in_service_q[i] && !claim_mask[i]
                            && (prio_q[i] > thresh_q);
      end
   end

   // Edge mode holds until claimed; a same-cycle edge re-sets over the claim.
   assign pending_d = (edge_sel_q & (edge_det | (pending_q & ~claim_mask)))
                    | (~edge_sel_q & s);

   ext_int_prio_tree #(
      .NUM_SRC (NUM_SRC)
   ) u_prio_tree (
      .valid  (eligible),
      .prio   (prio_q),
      .win_id (win_id_d)
   );

   always_comb begin
      rdata_d = '0;
      if (bus.rd_en) begin
         case (bus.addr)
            AddrPending:   rdata_d[NUM_SRC-1:0] = pending_q;
            AddrEnable:    rdata_d[NUM_SRC-1:0] = enable_q;
            AddrEdgeSel:   rdata_d[NUM_SRC-1:0] = edge_sel_q;
            AddrThreshold: rdata_d[2:0]         = thresh_q;
            AddrClaim:     rdata_d[3:0]         = win_id_q;
            AddrPrio: begin
               for (int i = 0; i < NUM_SRC; i++) rdata_d[4*i +: 3] = prio_q[i];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_sync_n) begin
         pending_q    <= '0;
         enable_q     <= '0;
         edge_sel_q   <= '0;
         in_service_q <= '0;
         thresh_q     <= '0;
         prio_q       <= '0;
         win_id_q     <= '0;
         rdata_q      <= '0;
      end else begin
         pending_q    <= pending_d;
         in_service_q <= (in_service_q & ~complete_mask) | claim_mask;
         win_id_q     <= win_id_d;
         rdata_q      <= rdata_d;
         if (bus.wr_en) begin
            case (bus.addr)
               AddrEnable:    enable_q   <= bus.wdata[NUM_SRC-1:0];
               AddrEdgeSel:   edge_sel_q <= bus.wdata[NUM_SRC-1:0];
               AddrThreshold: thresh_q   <= bus.wdata[2:0];
               AddrPrio: begin
                  for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= bus.wdata[4*i +: 3];
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rdata           = rdata_q;
   assign bus.meip            = (win_id_q != '0);
   assign bus.custom_int_code = 31'(CODE_BASE) + 31'(win_id_q);

endmodule
